// File: rtl/sddr_cpu_bridge.sv
// sddr_cpu_bridge: CPU word port to SDDR line-burst port bridge.
// Optional feature macro SDDR_BRIDGE_LINE_BUF_EN keeps the last line as a
// single-entry buffer so repeat accesses hit; without it every access misses.
`timescale 1ns/1ps
module sddr_cpu_bridge #(
    parameter int ADDRESS_BITS = 27,
    parameter int LINE_BITS    = 128
) (
    input  logic                    cpu_clock_i,
    input  logic                    reset_i,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ack,
    input  logic [31:0]             cpu_req_addr,
    input  logic                    cpu_req_write,
    input  logic [31:0]             cpu_req_wdata,
    input  logic [3:0]              cpu_req_wmask,
    output logic                    cpu_rsp_valid,
    output logic [31:0]             cpu_rsp_data,
    output logic                    data_cmd_valid,
    output logic [ADDRESS_BITS-1:0] data_cmd_address,
    output logic                    data_cmd_write,
    output logic [LINE_BITS-1:0]    data_cmd_data_o,
    input  logic                    data_cmd_ack,
    input  logic                    data_rsp_ready,
    input  logic [LINE_BITS-1:0]    data_rsp_data_i
);

    localparam int TAG_BITS = ADDRESS_BITS - 4;

    typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, WB_REQ, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic [LINE_BITS-1:0]  line;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            req_word;
    logic                  req_write;
    logic [31:0]           req_wdata;
    logic [3:0]            req_wmask;
    logic [TAG_BITS-1:0]   in_tag;
    logic [1:0]            in_word;
    logic                  accept;
    logic                  hit;
    logic                  fill_done;
    logic                  unused_addr_bits;

    assign in_tag           = cpu_req_addr[ADDRESS_BITS-1:4];
    assign in_word          = cpu_req_addr[3:2];
    assign accept           = cpu_req_valid && state == IDLE && !reset_i;
    assign fill_done        = state == FILL_WAIT && data_rsp_ready;
    assign unused_addr_bits = &{1'b0, cpu_req_addr[31:ADDRESS_BITS], cpu_req_addr[1:0]};

    function automatic logic [LINE_BITS-1:0] merge_word(
        input logic [LINE_BITS-1:0] line_in,
        input logic [1:0]           k,
        input logic [31:0]          wdata,
        input logic [3:0]           wmask
    );
        logic [LINE_BITS-1:0] merged;
        merged = line_in;
        for (int b = 0; b < 4; b++)
            if (wmask[b]) merged[32*k + 8*b +: 8] = wdata[8*b +: 8];
        return merged;
    endfunction

`ifdef SDDR_BRIDGE_LINE_BUF_EN
    logic                line_valid;
    logic [TAG_BITS-1:0] line_tag;

    // Remember which line the buffer holds once a fill lands.
    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            line_valid <= 1'b0;
            line_tag   <= '0;
        end else if (fill_done) begin
            line_valid <= 1'b1;
            line_tag   <= req_tag;
        end
    end

    assign hit = line_valid && line_tag == in_tag;
`else
    assign hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Latch the request on acceptance; load or merge into the line buffer.
    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            line      <= '0;
            req_tag   <= '0;
            req_word  <= '0;
            req_write <= 1'b0;
            req_wdata <= '0;
            req_wmask <= '0;
        end else begin
            if (accept) begin
                req_tag   <= in_tag;
                req_word  <= in_word;
                req_write <= cpu_req_write;
                req_wdata <= cpu_req_wdata;
                req_wmask <= cpu_req_wmask;
                if (hit && cpu_req_write)
                    line <= merge_word(line, in_word, cpu_req_wdata, cpu_req_wmask);
            end
            if (fill_done)
                line <= req_write ? merge_word(data_rsp_data_i, req_word, req_wdata, req_wmask)
                                  : data_rsp_data_i;
        end
    end

    // Next state and outputs; outputs are zero outside the states that own them.
    always_comb begin
        state_next       = state;
        cpu_req_ack      = 1'b0;
        cpu_rsp_valid    = 1'b0;
        cpu_rsp_data     = '0;
        data_cmd_valid   = 1'b0;
        data_cmd_address = '0;
        data_cmd_write   = 1'b0;
        data_cmd_data_o  = '0;
        case (state)
            IDLE: begin
                cpu_req_ack = !reset_i;
                if (accept) state_next = hit ? (cpu_req_write ? WB_REQ : RESP) : FILL_REQ;
            end
            FILL_REQ: begin
                data_cmd_valid   = 1'b1;
                data_cmd_address = {req_tag, 4'b0000};
                if (data_cmd_ack) state_next = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (data_rsp_ready) state_next = req_write ? WB_REQ : RESP;
            end
            WB_REQ: begin
                data_cmd_valid   = 1'b1;
                data_cmd_write   = 1'b1;
                data_cmd_address = {req_tag, 4'b0000};
                data_cmd_data_o  = line;
                if (data_cmd_ack) state_next = RESP;
            end
            RESP: begin
                cpu_rsp_valid = 1'b1;
                cpu_rsp_data  = line[32*req_word +: 32];
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/sddr_cpu_bridge.md
SDDR_CPU_BRIDGE -- requirements
Module: sddr_cpu_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 27: byte-address width of the DRAM data command port.
REQ-002 SHALL have parameter LINE_BITS, default 128: burst line width (BURST_LENGTH*DATA_BITS); 16-byte line.
REQ-003 SHALL have the port cpu_clock_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have the port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have the port cpu_req_valid  input  1  CPU word request present.
REQ-006 SHALL have the port cpu_req_ack  output  1  request accepted when valid&&ack.
REQ-007 SHALL have the port cpu_req_addr  input  32  byte address; bits [1:0] ignored, bits above ADDRESS_BITS-1 ignored.
REQ-008 SHALL have the ports cpu_req_write  input  1, cpu_req_wdata  input  32, cpu_req_wmask  input  4 (byte enables).
REQ-009 SHALL have the ports cpu_rsp_valid  output  1  one-cycle completion pulse, and cpu_rsp_data  output  32  word.
REQ-010 SHALL have the ports data_cmd_valid  output  1, data_cmd_address  output  ADDRESS_BITS, data_cmd_write  output  1, data_cmd_data_o  output  LINE_BITS.
REQ-011 SHALL have the port data_cmd_ack  input  1  controller accepts command when valid&&ack.
REQ-012 SHALL have the ports data_rsp_ready  input  1  read line present, and data_rsp_data_i  input  LINE_BITS.

Function
REQ-013 SHALL implement states IDLE, FILL_REQ, FILL_WAIT, WB_REQ, RESP.
REQ-014 SHALL drive cpu_req_ack=1 only in IDLE; request fields are latched on acceptance.
REQ-015 SHALL treat line address = cpu_req_addr[ADDRESS_BITS-1:4] and data_cmd_address = {line address, 4'b0000}.
REQ-016 SHALL select word k = addr[3:2] as line bits [32k+31:32k].
REQ-017 SHALL, on read hit (line buffer valid, tag equal), go IDLE->RESP; cpu_rsp_valid asserted the cycle after acceptance (latency 1).
REQ-018 SHALL, on read miss or write miss, go IDLE->FILL_REQ with data_cmd_valid=1, data_cmd_write=0.
REQ-019 SHALL hold data_cmd_valid, address, write, data stable until data_cmd_ack=1; never withdraw a command.
REQ-020 SHALL go FILL_REQ->FILL_WAIT on data_cmd_ack; FILL_WAIT exits on first cycle data_rsp_ready=1, capturing data_rsp_data_i, tag, valid=1.
REQ-021 SHALL, after fill, go to RESP for reads and WB_REQ for writes.
REQ-022 SHALL, for writes, merge cpu_req_wdata into the selected word per wmask byte lanes, update the line buffer, and present the merged line in WB_REQ with data_cmd_write=1.
REQ-023 SHALL, on write hit, go IDLE->WB_REQ directly, skipping fill.
REQ-024 SHALL go WB_REQ->RESP on data_cmd_ack; no read response is awaited for writes.
REQ-025 SHALL, in RESP, pulse cpu_rsp_valid one cycle with the (merged for writes) word, then return to IDLE.
REQ-026 SHALL issue the write-back even for wmask=4'b0000 (line unchanged).
REQ-027 SHALL ignore data_rsp_ready outside FILL_WAIT.

Reset
REQ-028 SHALL on reset_i=1 force IDLE, line buffer invalid, and all outputs 0 except cpu_req_ack=1 after release (cpu_req_ack=0 while reset_i=1).
REQ-029 SHALL on reset mid-operation drop data_cmd_valid next cycle and emit no cpu_rsp_valid for the aborted request.

Configuration
REQ-030 SHALL with SDDR_BRIDGE_LINE_BUF_EN defined retain the single-line buffer and honour hits per REQ-017/REQ-023.
REQ-031 SHALL without SDDR_BRIDGE_LINE_BUF_EN treat every access as miss: every read fills, every write fills then writes back.

Verification
REQ-032 SHALL cover: read 0x100 cold, controller acks after 3 cycles, data_rsp_ready after 10 with line word1=0xDEADBEEF, read 0x104 -> cpu_rsp_data=0xDEADBEEF, one fill at address 0x100.
REQ-033 SHALL cover: reread 0x104 with LINE_BUF_EN -> cpu_rsp_valid 1 cycle after accept, no data_cmd_valid; without macro -> new fill issued.
REQ-034 SHALL cover: write 0x108 wdata 0x11223344 wmask 4'b0101 over word 0xAABBCCDD -> write-back line word2=0xAA22CC44, cpu_rsp_data=0xAA22CC44.
REQ-035 SHALL cover: data_cmd_ack held 0 for 20 cycles -> data_cmd_valid/address/data stable throughout, cpu_req_ack=0.
REQ-036 SHALL cover: reset_i pulsed in FILL_WAIT, then late data_rsp_ready -> no cpu_rsp_valid, next read 0x100 refills.
REQ-037 SHALL cover: spurious data_rsp_ready in IDLE -> line buffer and outputs unchanged.
